// File: rtl/i2c_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_pkg : byte/bit-count types and constants shared by the I2C byte stages
// Revision: 1.0
// ----------------------------------------------------------------------------
package i2c_pkg;

   localparam int I2C_BYTE_W        = 8;
   localparam int I2C_BIT_CNT_W     = 3;
   localparam int I2C_BITS_PER_BYTE = 8;

   typedef logic [I2C_BYTE_W-1:0]    i2c_byte_t;
   typedef logic [I2C_BIT_CNT_W-1:0] i2c_bit_cnt_t;

   localparam i2c_bit_cnt_t I2C_LAST_BIT = i2c_bit_cnt_t'(I2C_BITS_PER_BYTE - 1);

   function automatic i2c_byte_t i2c_shift_in(input i2c_byte_t cur, input logic b,
                                              input logic lsb_first);
      return lsb_first ? {b, cur[I2C_BYTE_W-1:1]} : {cur[I2C_BYTE_W-2:0], b};
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_rx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_rx_fifo : FIFO_DEPTH x 8 synchronous FIFO with flush, full/empty, level
// Revision: 1.0
// ----------------------------------------------------------------------------
module i2c_rx_fifo
   import i2c_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int LEVEL_W    = $clog2(FIFO_DEPTH + 1)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               push,
   input  i2c_byte_t          push_data,
   input  logic               pop,
   output i2c_byte_t          head_data,
   output logic               full,
   output logic               empty,
   output logic [LEVEL_W-1:0] level
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   i2c_byte_t          mem_q [FIFO_DEPTH];
   i2c_byte_t          mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               pop_ok;
   logic               push_ok;

   assign full      = (level_q == LEVEL_W'(FIFO_DEPTH));
   assign empty     = (level_q == '0);
   assign level     = level_q;
   assign head_data = mem_q[rd_ptr_q];

   // A push into a full FIFO is only accepted when the head leaves on the same edge.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      pop_ok   = pop & ~empty;
      push_ok  = push & (~full | pop_ok);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push_ok && !pop_ok) begin
            level_d = level_q + LEVEL_W'(1);
         end else if (pop_ok && !push_ok) begin
            level_d = level_q - LEVEL_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/i2c_master_rx_deserializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_master_rx_deserializer : assembles read-byte bits into bytes, queues them
// Option macro I2C_RX_LSB_FIRST_EN: first received bit lands in out_data[0].
// Revision: 1.0
// ----------------------------------------------------------------------------
module i2c_master_rx_deserializer
   import i2c_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int LEVEL_W    = $clog2(FIFO_DEPTH + 1)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               bit_in,
   input  logic               load,
   input  logic               byte_done,
   output logic [7:0]         out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LEVEL_W-1:0] fifo_level,
   output logic               overflow,
   output logic               frame_error
);

`ifdef I2C_RX_LSB_FIRST_EN
   localparam logic LSB_FIRST = 1'b1;
`else
   localparam logic LSB_FIRST = 1'b0;
`endif

   logic         load_q;
   logic         done_q;
   i2c_byte_t    shift_reg_q, shift_reg_d;
   i2c_bit_cnt_t bit_cnt_q, bit_cnt_d;
   logic         overflow_q, overflow_d;
   logic         frame_error_q, frame_error_d;
   logic         capture;
   logic         done_rise;
   logic         push;
   i2c_byte_t    push_data;
   logic         fifo_full;
   logic         fifo_empty;

   // The capture is folded into bit_cnt_d before the end-of-byte check, so an
   // 8th bit arriving together with byte_done completes cleanly.
   always_comb begin
      capture       = load & ~load_q;
      done_rise     = byte_done & ~done_q;
      shift_reg_d   = shift_reg_q;
      bit_cnt_d     = bit_cnt_q;
      overflow_d    = overflow_q;
      frame_error_d = 1'b0;
      push          = 1'b0;
      push_data     = i2c_shift_in(shift_reg_q, bit_in, LSB_FIRST);
      if (capture) begin
         shift_reg_d = push_data;
         if (bit_cnt_q == I2C_LAST_BIT) begin
            push      = 1'b1;
            bit_cnt_d = '0;
         end else begin
            bit_cnt_d = bit_cnt_q + I2C_BIT_CNT_W'(1);
         end
      end
      if (done_rise && (bit_cnt_d != '0)) begin
         frame_error_d = 1'b1;
         bit_cnt_d     = '0;
         shift_reg_d   = '0;
      end
      // Full with the head leaving this edge is not an overflow.
      if (push && fifo_full && !out_ready) begin
         overflow_d = 1'b1;
      end
      if (clear) begin
         shift_reg_d   = '0;
         bit_cnt_d     = '0;
         overflow_d    = 1'b0;
         frame_error_d = 1'b0;
         push          = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         load_q        <= 1'b0;
         done_q        <= 1'b0;
         shift_reg_q   <= '0;
         bit_cnt_q     <= '0;
         overflow_q    <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         load_q        <= load;
         done_q        <= byte_done;
         shift_reg_q   <= shift_reg_d;
         bit_cnt_q     <= bit_cnt_d;
         overflow_q    <= overflow_d;
         frame_error_q <= frame_error_d;
      end
   end

   i2c_rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .LEVEL_W    (LEVEL_W)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (clear),
      .push      (push),
      .push_data (push_data),
      .pop       (out_ready),
      .head_data (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign out_valid   = ~fifo_empty;
   assign overflow    = overflow_q;
   assign frame_error = frame_error_q;

endmodule
`default_nettype wire
